// File: rtl/fwrisc_exec_formal_pkg.sv
// Shared types and constants for the fwrisc_exec formal/simulation checkers.
//   chk_state_e : progress-checker FSM states
//   chk_code_e  : failure codes reported on chk_fail_code (lowest code wins)
//   OP_TYPE_*   : op_type encodings used to build allow-masks
//   first_code  : picks the winning failure code from a per-code flag vector
package fwrisc_exec_formal_pkg;

    typedef enum logic [1:0] {
        CHK_IDLE = 2'd0,
        CHK_EXEC = 2'd1,
        CHK_DONE = 2'd2,
        CHK_FAIL = 2'd3
    } chk_state_e;

    typedef enum logic [2:0] {
        CODE_NONE       = 3'd0,
        CODE_TIMEOUT    = 3'd1,
        CODE_ILLEGAL_OP = 3'd2,
        CODE_ORPHAN     = 3'd3,
        CODE_STRAY_WEN  = 3'd4,
        CODE_DROP       = 3'd5
    } chk_code_e;

    localparam logic [4:0] OP_TYPE_ARITH  = 5'd0;
    localparam logic [4:0] OP_TYPE_BRANCH = 5'd1;
    localparam logic [4:0] OP_TYPE_LDST   = 5'd2;
    localparam logic [4:0] OP_TYPE_CSR    = 5'd3;

    // Bit n of flags set means failure code n was detected this cycle.
    function automatic chk_code_e first_code(input logic [5:1] flags);
        chk_code_e code;
        code = CODE_NONE;
        if (flags[1]) begin
            code = CODE_TIMEOUT;
        end else if (flags[2]) begin
            code = CODE_ILLEGAL_OP;
        end else if (flags[3]) begin
            code = CODE_ORPHAN;
        end else if (flags[4]) begin
            code = CODE_STRAY_WEN;
        end else if (flags[5]) begin
            code = CODE_DROP;
        end else begin
            code = CODE_NONE;
        end
        return code;
    endfunction

endpackage

// File: rtl/fwrisc_formal_watchdog.sv
// Saturating latency counter shared by the formal checkers.
//   clock, reset : clock, asynchronous active-high reset
//   load         : start a new measurement (count becomes 1 = the load cycle)
//   clear        : return count to 0
//   tick         : add one elapsed cycle (saturates at MAX)
//   count        : cycles measured so far
//   expired      : count has reached MAX, so one more cycle would exceed it
module fwrisc_formal_watchdog #(
    parameter int MAX = 16,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         expired
);

    logic [W-1:0] count_r;

    // Latency counter: clear has priority over load, load over tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= {W{1'b0}};
        end else if (clear) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= W'(1'b1);
        end else if (tick && (count_r != W'(MAX))) begin
            count_r <= count_r + W'(1'b1);
        end
    end

    assign count   = count_r;
    assign expired = (count_r == W'(MAX));

endmodule

// File: rtl/fwrisc_exec_formal_progress_checker.sv
// Liveness/legality checker placed beside fwrisc_exec.
// Follows each instruction from decode_valid to instr_complete, bounds its
// latency, checks retiring op types against OP_TYPE_MASK and watches the
// rd-write and data-bus handshakes. Reports a sticky first-failure code,
// completion count, per-op coverage and worst latency.
//   clock, reset            : clock, asynchronous active-high reset
//   decode_valid            : instruction presented to exec
//   instr_complete, op_type : instruction retires with this op type
//   rd_wen, rd_waddr        : register write port (write only legal on retire)
//   dvalid, dready          : data-bus request / accept
//   chk_fail, chk_fail_code : sticky failure and first failure code
//   chk_done                : N_INSTR legal completions reached (sticky)
//   instr_count, op_seen, latency_max : progress and coverage
module fwrisc_exec_formal_progress_checker
    import fwrisc_exec_formal_pkg::*;
#(
    parameter int          MAX_LATENCY  = 16,
    parameter int          N_INSTR      = 8,
    parameter logic [31:0] OP_TYPE_MASK = 32'h0000_0001,
    parameter int          ASSERT_EN    = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           decode_valid,
    input  logic                           instr_complete,
    input  logic [4:0]                     op_type,
    input  logic                           rd_wen,
    input  logic [5:0]                     rd_waddr,
    input  logic                           dvalid,
    input  logic                           dready,
    output logic                           chk_fail,
    output logic [2:0]                     chk_fail_code,
    output logic                           chk_done,
    output logic [$clog2(N_INSTR+1)-1:0]   instr_count,
    output logic [31:0]                    op_seen,
    output logic [$clog2(MAX_LATENCY+1)-1:0] latency_max
);

    localparam int CW = $clog2(N_INSTR + 1);
    localparam int LW = $clog2(MAX_LATENCY + 1);

    chk_state_e     state_r;
    chk_state_e     state_nxt_s;
    chk_code_e      code_r;
    logic           chk_fail_r;
    logic           done_r;
    logic [CW-1:0]  count_r;
    logic [31:0]    op_seen_r;
    logic [LW-1:0]  lat_max_r;
    logic           req_hold_r;

    logic [LW-1:0]  wd_count_s;
    logic           wd_expired_s;
    logic           wd_load_s;
    logic           wd_clear_s;
    logic           wd_tick_s;
    logic           retire_s;
    logic [LW-1:0]  retire_lat_s;
    logic [5:1]     flags_s;
    logic           fail_s;
    logic           op_legal_s;
    logic [CW-1:0]  count_inc_s;

    // The write address carries no rule of its own here.
    logic unused_waddr_s;
    assign unused_waddr_s = ^rd_waddr;

    assign op_legal_s  = OP_TYPE_MASK[op_type];
    assign count_inc_s = count_r + CW'(1'b1);

    fwrisc_formal_watchdog #(
        .MAX (MAX_LATENCY),
        .W   (LW)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .load    (wd_load_s),
        .clear   (wd_clear_s),
        .tick    (wd_tick_s),
        .count   (wd_count_s),
        .expired (wd_expired_s)
    );

    // Failure detection, retire decode and next-state selection.
    always_comb begin
        flags_s      = 5'b0_0000;
        retire_s     = 1'b0;
        retire_lat_s = {LW{1'b0}};
        wd_load_s    = 1'b0;
        wd_clear_s   = 1'b0;
        wd_tick_s    = 1'b0;
        state_nxt_s  = state_r;

        // Handshake checks stay armed in DONE; FAIL is quiet.
        if (state_r != CHK_FAIL) begin
            flags_s[4] = rd_wen & ~instr_complete;
            flags_s[5] = req_hold_r & ~dvalid;
        end else begin
            flags_s[5:4] = 2'b00;
        end

        case (state_r)
            CHK_IDLE: begin
                if (instr_complete && !decode_valid) begin
                    flags_s[3] = 1'b1;
                end else if (decode_valid && instr_complete) begin
                    retire_s     = 1'b1;
                    retire_lat_s = LW'(1'b1);
                end else if (decode_valid) begin
                    wd_load_s = 1'b1;
                end else begin
                    wd_clear_s = 1'b1;
                end
            end
            CHK_EXEC: begin
                // The count already covers MAX_LATENCY cycles, so this cycle
                // overruns whether or not the instruction completes in it.
                if (wd_expired_s) begin
                    flags_s[1] = 1'b1;
                end else if (instr_complete) begin
                    retire_s     = 1'b1;
                    retire_lat_s = wd_count_s + LW'(1'b1);
                    // A decode alongside the retire starts the next instruction.
                    if (decode_valid) begin
                        wd_load_s = 1'b1;
                    end else begin
                        wd_clear_s = 1'b1;
                    end
                end else if (decode_valid) begin
                    flags_s[3] = 1'b1;
                end else begin
                    wd_tick_s = 1'b1;
                end
            end
            default: begin
                wd_clear_s = 1'b0;
            end
        endcase

        flags_s[2] = retire_s & ~op_legal_s;
        fail_s     = |flags_s;

        if (fail_s) begin
            state_nxt_s = CHK_FAIL;
        end else if (retire_s && (count_inc_s == CW'(N_INSTR))) begin
            state_nxt_s = CHK_DONE;
        end else if (wd_load_s) begin
            state_nxt_s = CHK_EXEC;
        end else if (retire_s) begin
            state_nxt_s = CHK_IDLE;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, sticky flags and retire statistics.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= CHK_IDLE;
            req_hold_r <= 1'b0;
            chk_fail_r <= 1'b0;
            code_r     <= CODE_NONE;
            done_r     <= 1'b0;
            count_r    <= {CW{1'b0}};
            op_seen_r  <= 32'h0000_0000;
            lat_max_r  <= {LW{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            req_hold_r <= dvalid & ~dready;
            // fail_s is never raised in FAIL, so the first code is kept.
            if (fail_s) begin
                chk_fail_r <= 1'b1;
                code_r     <= first_code(flags_s);
            end else if (retire_s) begin
                count_r            <= count_inc_s;
                op_seen_r[op_type] <= 1'b1;
                if (retire_lat_s > lat_max_r) begin
                    lat_max_r <= retire_lat_s;
                end
                if (count_inc_s == CW'(N_INSTR)) begin
                    done_r <= 1'b1;
                end
            end
        end
    end

    generate
        if (ASSERT_EN != 0) begin : g_assert
            // Every newly detected failure is a property violation.
            always_ff @(posedge clock) begin
                if (!reset) begin
                    assert (!fail_s);
                end
            end
        end
    endgenerate

    assign chk_fail      = chk_fail_r;
    assign chk_fail_code = code_r;
    assign chk_done      = done_r;
    assign instr_count   = count_r;
    assign op_seen       = op_seen_r;
    assign latency_max   = lat_max_r;

endmodule

// File: tb/tb_fwrisc_exec_formal_progress_checker.sv
// Self-checking bench: directed scenarios plus randomized protocol traffic,
// compared every cycle against a timestamp-based model of the checker rules.
module tb_fwrisc_exec_formal_progress_checker;

    localparam int          MAXL = 16;
    localparam int          NI   = 5;
    localparam logic [31:0] MASK = 32'h0000_000B;

    logic        clock;
    logic        reset;
    logic        decode_valid;
    logic        instr_complete;
    logic [4:0]  op_type;
    logic        rd_wen;
    logic [5:0]  rd_waddr;
    logic        dvalid;
    logic        dready;
    logic        chk_fail;
    logic [2:0]  chk_fail_code;
    logic        chk_done;
    logic [2:0]  instr_count;
    logic [31:0] op_seen;
    logic [4:0]  latency_max;

    int n_checks;
    int n_errors;

    // model state
    bit          m_fail;
    int          m_code;
    bit          m_done;
    int          m_count;
    logic [31:0] m_seen;
    int          m_lmax;
    bit          m_busy;
    int          m_start;
    bit          m_prev_req;
    int          cyc;

    fwrisc_exec_formal_progress_checker #(
        .MAX_LATENCY  (MAXL),
        .N_INSTR      (NI),
        .OP_TYPE_MASK (MASK),
        .ASSERT_EN    (0)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .decode_valid   (decode_valid),
        .instr_complete (instr_complete),
        .op_type        (op_type),
        .rd_wen         (rd_wen),
        .rd_waddr       (rd_waddr),
        .dvalid         (dvalid),
        .dready         (dready),
        .chk_fail       (chk_fail),
        .chk_fail_code  (chk_fail_code),
        .chk_done       (chk_done),
        .instr_count    (instr_count),
        .op_seen        (op_seen),
        .latency_max    (latency_max)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fail = 0; m_code = 0; m_done = 0; m_count = 0; m_seen = 32'h0;
        m_lmax = 0; m_busy = 0; m_start = 0; m_prev_req = 0;
    endtask

    // Apply the checker rules to the inputs sampled at this clock edge.
    task automatic model_step();
        logic [5:0] fl;
        bit ret;
        int rlat;
        bit nbusy;
        int nstart;
        int lat;
        fl = 6'b0; ret = 0; rlat = 0; nbusy = m_busy; nstart = m_start;
        if (!m_fail) begin
            if (rd_wen && !instr_complete) fl[4] = 1'b1;
            if (m_prev_req && !dvalid) fl[5] = 1'b1;
            if (!m_done) begin
                if (!m_busy) begin
                    if (instr_complete && !decode_valid) fl[3] = 1'b1;
                    else if (decode_valid && instr_complete) begin ret = 1; rlat = 1; end
                    else if (decode_valid) begin nbusy = 1; nstart = cyc; end
                end else begin
                    lat = cyc - m_start + 1;
                    if (lat > MAXL) fl[1] = 1'b1;
                    else if (instr_complete) begin
                        ret = 1; rlat = lat; nbusy = decode_valid; nstart = cyc;
                    end else if (decode_valid) fl[3] = 1'b1;
                end
                if (ret && !MASK[op_type]) fl[2] = 1'b1;
            end
            if (fl != 6'b0) begin
                m_fail = 1;
                for (int c = 5; c >= 1; c--) if (fl[c]) m_code = c;
            end else begin
                if (ret) begin
                    m_count++;
                    m_seen[op_type] = 1'b1;
                    if (rlat > m_lmax) m_lmax = rlat;
                    if (m_count == NI) m_done = 1;
                end
                m_busy = nbusy;
                m_start = nstart;
            end
        end
        m_prev_req = dvalid && !dready;
        cyc++;
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, "_fail"},  {31'b0, chk_fail}, {31'b0, m_fail});
        check_val({tag, "_code"},  {29'b0, chk_fail_code}, m_code);
        check_val({tag, "_done"},  {31'b0, chk_done}, {31'b0, m_done});
        check_val({tag, "_count"}, {29'b0, instr_count}, m_count);
        check_val({tag, "_seen"},  op_seen, m_seen);
        check_val({tag, "_lmax"},  {27'b0, latency_max}, m_lmax);
    endtask

    task automatic idle_inputs();
        decode_valid = 0; instr_complete = 0; op_type = 5'd0; rd_wen = 0;
        rd_waddr = 6'd0; dvalid = 0; dready = 0;
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_step();
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        #1;
        model_reset();
        compare_all("rst");
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int rem;
        bit req;
        n_checks = 0; n_errors = 0; cyc = 0;
        idle_inputs();
        reset = 1'b1;
        model_reset();
        @(posedge clock); #1;
        do_reset();

        // five ARITH instructions, latency 3 each
        for (int i = 0; i < 5; i++) begin
            decode_valid = 1; step("arith_dec");
            decode_valid = 0; step("arith_mid");
            instr_complete = 1; op_type = 5'd0; rd_wen = 1; rd_waddr = 6'(i + 1); step("arith_cmp");
            instr_complete = 0; rd_wen = 0;
        end
        check_val("arith_done",  {31'b0, chk_done}, 32'd1);
        check_val("arith_lmax",  {27'b0, latency_max}, 32'd3);
        check_val("arith_seen",  op_seen, 32'h1);
        check_val("arith_count", {29'b0, instr_count}, 32'd5);
        // stray write after DONE still fails, done stays
        rd_wen = 1; step("done_stray");
        rd_wen = 0;
        check_val("done_stray_code", {29'b0, chk_fail_code}, 32'd4);
        check_val("done_stray_done", {31'b0, chk_done}, 32'd1);

        // decode+complete same cycle
        do_reset();
        decode_valid = 1; instr_complete = 1; op_type = 5'd0; step("same_cyc");
        instr_complete = 0;
        check_val("same_cyc_lmax", {27'b0, latency_max}, 32'd1);
        step("same_cyc_next_dec");
        check_val("same_cyc_no_overlap", {31'b0, chk_fail}, 32'd0);
        decode_valid = 0; instr_complete = 1; op_type = 5'd1; step("same_cyc_cmp2");
        instr_complete = 0;
        check_val("same_cyc_lmax2", {27'b0, latency_max}, 32'd2);

        // timeout
        do_reset();
        decode_valid = 1; step("to_dec");
        decode_valid = 0;
        repeat (15) step("to_wait");
        check_val("to_before", {31'b0, chk_fail}, 32'd0);
        step("to_edge");
        check_val("to_fail", {31'b0, chk_fail}, 32'd1);
        check_val("to_code", {29'b0, chk_fail_code}, 32'd1);

        // illegal op
        do_reset();
        decode_valid = 1; step("ill_dec");
        decode_valid = 0; instr_complete = 1; op_type = 5'd2; step("ill_cmp");
        instr_complete = 0;
        check_val("ill_code",  {29'b0, chk_fail_code}, 32'd2);
        check_val("ill_count", {29'b0, instr_count}, 32'd0);

        // orphan complete then stray write
        do_reset();
        instr_complete = 1; step("orph");
        instr_complete = 0; rd_wen = 1; step("orph_stray");
        rd_wen = 0;
        check_val("orph_code", {29'b0, chk_fail_code}, 32'd3);

        // withdrawn data request
        do_reset();
        dvalid = 1; dready = 0; step("drop_req");
        dvalid = 0; step("drop_wd");
        check_val("drop_code", {29'b0, chk_fail_code}, 32'd5);

        // reset mid-EXEC, then clean restart
        do_reset();
        decode_valid = 1; step("mid_dec");
        decode_valid = 0; step("mid_exec");
        do_reset();
        decode_valid = 1; step("rs_dec");
        decode_valid = 0; instr_complete = 1; op_type = 5'd1; step("rs_cmp");
        instr_complete = 0;
        check_val("rs_count", {29'b0, instr_count}, 32'd1);
        check_val("rs_lmax",  {27'b0, latency_max}, 32'd2);
        check_val("rs_seen",  op_seen, 32'h2);

        // randomized, mostly protocol-abiding traffic with rare faults
        for (int ep = 0; ep < 12; ep++) begin
            do_reset();
            rem = 0; req = 0;
            for (int c = 0; c < 80; c++) begin
                decode_valid = 0; instr_complete = 0; rd_wen = 0;
                if (rem == 0) begin
                    if ($urandom_range(0, 1) == 1) begin
                        decode_valid = 1;
                        rem = (($urandom_range(0, 15) == 0) ? 17 : $urandom_range(1, 6)) - 1;
                        if (rem == 0) instr_complete = 1;
                    end else if ($urandom_range(0, 63) == 0) begin
                        instr_complete = 1;
                    end
                end else begin
                    rem--;
                    if (rem == 0) instr_complete = 1;
                    else if ($urandom_range(0, 63) == 0) decode_valid = 1;
                end
                if (instr_complete) begin
                    case ($urandom_range(0, 2))
                        0: op_type = 5'd0;
                        1: op_type = 5'd1;
                        default: op_type = 5'd3;
                    endcase
                    if ($urandom_range(0, 15) == 0) op_type = 5'($urandom_range(0, 31));
                    rd_wen = 1'($urandom_range(0, 1));
                end else begin
                    rd_wen = ($urandom_range(0, 63) == 0);
                end
                rd_waddr = 6'($urandom_range(0, 63));
                if (req) begin
                    dvalid = ($urandom_range(0, 63) != 0);
                end else begin
                    dvalid = ($urandom_range(0, 2) == 0);
                end
                dready = 1'($urandom_range(0, 1));
                req = dvalid && !dready;
                step("rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
